// File: rtl/periph_spi_arbiter_if.sv
// periph_spi_arbiter_if -- request/grant handshake and SPI pin bundle for
// periph_spi_arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the requesters, the MCU select and the SPI devices.
interface periph_spi_arbiter_if #(
   parameter int WIDTH = 24
);
   logic             cs2;
   logic [1:0]       req;
   logic [2:0]       req_cs0;
   logic [2:0]       req_cs1;
   logic [WIDTH-1:0] req_data0;
   logic [WIDTH-1:0] req_data1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic [WIDTH-1:0] rdata;
   logic             busy;
   logic             mcu_owns;
   logic             sclk;
   logic             mosi;
   logic [7:0]       cs_vec;
   logic [7:0]       miso_vec;

   modport slave (
      input  cs2, req, req_cs0, req_cs1, req_data0, req_data1, miso_vec,
      output gnt, done, rdata, busy, mcu_owns, sclk, mosi, cs_vec
   );

   modport master (
      output cs2, req, req_cs0, req_cs1, req_data0, req_data1, miso_vec,
      input  gnt, done, rdata, busy, mcu_owns, sclk, mosi, cs_vec
   );
endinterface

// File: rtl/periph_spi_arbiter.sv
// periph_spi_arbiter -- shares one SPI mode-0 master between two requesters
// and an MCU pass-through path (cs2 low hands the bus to the MCU from IDLE).
// A transfer is SETUP (CLK_DIV), then SHIFT (WIDTH bits, 2*CLK_DIV each),
// then HOLD (CLK_DIV). So gnt-to-done is 2*CLK_DIV*(WIDTH+1) clk cycles.
// Optional macro PERIPH_SPI_ARB_ROUND_ROBIN_EN: when it is defined,
// arbitration is round-robin. When it is not defined, requester 0 always wins.
// WIDTH must be at least 2.
module periph_spi_arbiter #(
   parameter int WIDTH   = 24,
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   periph_spi_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, MCU} state_t;

   localparam int            BW       = $clog2(WIDTH + 1);
   localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_t           state_q;
   logic [7:0]       cnt_q;      // clk cycles within the current phase/half-period
   logic [BW-1:0]    bit_q;      // bit being shifted
   logic [2:0]       idx_q;      // granted chip-select index
   logic             owner_q;    // granted requester
   logic [WIDTH-1:0] tx_q;
   logic [WIDTH-1:0] rx_q;
   logic [WIDTH-1:0] rdata_q;
   logic             sclk_q;
   logic             mosi_q;
   logic [7:0]       cs_vec_q;
   logic [1:0]       gnt_q;
   logic [1:0]       done_q;

   logic             win_d;      // arbitration winner for this cycle
   logic             miso_d;

`ifdef PERIPH_SPI_ARB_ROUND_ROBIN_EN
   logic             ptr_q;      // requester with priority on the next contest

   // Round-robin pick: the pointer breaks the tie when both requesters ask.
   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
      win_d = 1'b0;
      if (bus.req == 2'b11) win_d = ptr_q;
      else                  win_d = bus.req[1] & ~bus.req[0];
   end
`else
   // Fixed priority pick: requester 0 wins whenever it asks.
   always_comb begin
      win_d = 1'b0;
      if (!bus.req[0] && bus.req[1]) win_d = 1'b1;
   end
`endif

   assign miso_d = bus.miso_vec[idx_q];

   // Transfer FSM with registered SPI pins and handshake pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         idx_q    <= '0;
         owner_q  <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
         rdata_q  <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_vec_q <= 8'hFF;
         gnt_q    <= '0;
         done_q   <= '0;
`ifdef PERIPH_SPI_ARB_ROUND_ROBIN_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
         gnt_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (!bus.cs2) begin
                  state_q  <= MCU;
                  cs_vec_q <= 8'hFF;
               end else if (|bus.req) begin
                  state_q  <= SETUP;
                  cnt_q    <= '0;
                  owner_q  <= win_d;
                  idx_q    <= win_d ? bus.req_cs1 : bus.req_cs0;
                  tx_q     <= win_d ? bus.req_data1 : bus.req_data0;
                  mosi_q   <= win_d ? bus.req_data1[WIDTH-1] : bus.req_data0[WIDTH-1];
                  cs_vec_q <= ~(8'b1 << (win_d ? bus.req_cs1 : bus.req_cs0));
                  gnt_q    <= win_d ? 2'b10 : 2'b01;
`ifdef PERIPH_SPI_ARB_ROUND_ROBIN_EN
                  ptr_q    <= ~win_d;
`endif
               end
            end
            SETUP: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= SHIFT;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            SHIFT: begin
               if (cnt_q != DIV_LAST) begin
                  cnt_q <= cnt_q + 8'd1;
               end else begin
                  cnt_q <= '0;
                  if (!sclk_q) begin
                     // Rising SCLK edge: sample the selected device's MISO.
                     sclk_q <= 1'b1;
                     rx_q   <= {rx_q[WIDTH-2:0], miso_d};
                  end else begin
                     // Falling SCLK edge: advance MOSI, or finish after the last bit.
                     sclk_q <= 1'b0;
                     if (bit_q == BIT_LAST) begin
                        state_q <= HOLD;
                     end else begin
                        bit_q  <= bit_q + 1'b1;
                        tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
                        mosi_q <= tx_q[WIDTH-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (cnt_q == DIV_LAST) begin
                  state_q  <= IDLE;
                  cnt_q    <= '0;
                  cs_vec_q <= 8'hFF;
                  mosi_q   <= 1'b0;
                  rdata_q  <= rx_q;
                  done_q   <= owner_q ? 2'b10 : 2'b01;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            MCU: begin
               cs_vec_q <= 8'hFF;
               if (bus.cs2) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.mcu_owns = (state_q == MCU);
   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.cs_vec   = cs_vec_q;

endmodule
